// File: rtl/can_cmd_pkg.sv
// Shared definitions for the CAN command responder.
// Holds the frame opcodes, reply status codes, the reply flag OR-ed into
// the echoed opcode, the responder FSM state type and a small helper that
// classifies a received frame.
package can_cmd_pkg;

  // Opcodes carried in byte0 of a received frame.
  localparam logic [7:0] OpWrite = 8'h01;
  localparam logic [7:0] OpRead  = 8'h02;
  localparam logic [7:0] OpPing  = 8'h03;

  // Status codes carried in byte7 of a reply frame.
  localparam logic [7:0] StatusOk      = 8'h00;
  localparam logic [7:0] StatusBadCmd  = 8'h01;
  localparam logic [7:0] StatusBadAddr = 8'h02;

  // OR-ed into the opcode to mark a frame as a reply.
  localparam logic [7:0] ReplyFlag = 8'h80;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StSend
  } state_e;

  // Unknown opcodes win over a bad address; PING ignores the address.
  function automatic logic [7:0] frame_status(logic [7:0] opcode, logic addr_ok);
    if (opcode != OpWrite && opcode != OpRead && opcode != OpPing) begin
      return StatusBadCmd;
    end
    if (opcode != OpPing && !addr_ok) begin
      return StatusBadAddr;
    end
    return StatusOk;
  endfunction

endpackage

// File: rtl/can_cmd_responder.sv
// CAN command responder.
// Accepts one 8-byte command frame at a time from the CAN data link, decodes
// it (WRITE / READ / PING), performs the parameter register access and sends
// back one 8-byte reply frame. The next frame is only accepted once the reply
// has been handshaken.
//
// Ports:
//   sys_clk, reset_n                 clock, asynchronous active-low reset
//   system_initilization_done_in     high when frames may be accepted
//   rx_dw1r_in/rx_dw2r_in            received frame, byte0 = rx_dw1r_in[31:24]
//   rx_valid_in / rx_ready_out       receive handshake
//   tx_dw1r_out/tx_dw2r_out          reply frame, same byte order
//   tx_valid_out / tx_ready_in       transmit handshake
//   param_wr_en_out                  one-cycle register write strobe
//   param_addr_out                   register address (write and read)
//   param_wr_data_out                register write data
//   param_rd_data_in                 register contents, one cycle after address
//   err_cnt_out                      saturating count of rejected frames
module can_cmd_responder
  import can_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              system_initilization_done_in,

  input  logic [31:0]       rx_dw1r_in,
  input  logic [31:0]       rx_dw2r_in,
  input  logic              rx_valid_in,
  output logic              rx_ready_out,

  output logic [31:0]       tx_dw1r_out,
  output logic [31:0]       tx_dw2r_out,
  output logic              tx_valid_out,
  input  logic              tx_ready_in,

  output logic              param_wr_en_out,
  output logic [ADDR_W-1:0] param_addr_out,
  output logic [31:0]       param_wr_data_out,
  input  logic [31:0]       param_rd_data_in,

  output logic [7:0]        err_cnt_out
);

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  addr_byte_q, addr_byte_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] tx_dw1_q, tx_dw1_d;
  logic [31:0] tx_dw2_q, tx_dw2_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  err_q, err_d;

  logic        addr_ok;
  logic [31:0] payload;

  // Bytes 6-7 of a received frame carry no meaning.
  logic unused_rx_tail;
  assign unused_rx_tail = ^rx_dw2r_in[15:0];

  // Full byte1 is compared so that out-of-range addresses are not aliased
  // onto a valid register by the truncated param_addr_out.
  assign addr_ok = ({1'b0, addr_byte_q} < 9'(NUM_REGS));

  // armed_q keeps rx_ready_out low after reset until the first clock edge
  // that sees initialisation done.
  assign rx_ready_out      = armed_q && (state_q == StIdle) && system_initilization_done_in;
  assign tx_valid_out      = (state_q == StSend);
  assign tx_dw1r_out       = tx_dw1_q;
  assign tx_dw2r_out       = tx_dw2_q;
  assign param_wr_en_out   = (state_q == StExec) && (status_q == StatusOk) && (op_q == OpWrite);
  assign param_addr_out    = addr_byte_q[ADDR_W-1:0];
  assign param_wr_data_out = data_q;
  assign err_cnt_out       = err_q;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | system_initilization_done_in;
    op_d        = op_q;
    addr_byte_d = addr_byte_q;
    data_d      = data_q;
    status_d    = status_q;
    tx_dw1_d    = tx_dw1_q;
    tx_dw2_d    = tx_dw2_q;
    seq_d       = seq_q;
    err_d       = err_q;
    payload     = '0;

    unique case (state_q)
      StIdle: begin
        if (rx_valid_in && rx_ready_out) begin
          op_d        = rx_dw1r_in[31:24];
          addr_byte_d = rx_dw1r_in[23:16];
          data_d      = {rx_dw1r_in[15:0], rx_dw2r_in[31:16]};
          state_d     = StDecode;
        end
      end

      StDecode: begin
        // param_addr_out already presents byte1 here, so read data is
        // valid by the EXEC cycle.
        status_d = frame_status(op_q, addr_ok);
        state_d  = StExec;
      end

      StExec: begin
        if (status_q == StatusOk) begin
          if (op_q == OpRead) begin
            payload = param_rd_data_in;
          end else begin
            payload = data_q;
          end
        end else if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        tx_dw1_d = {op_q | ReplyFlag, addr_byte_q, payload[31:16]};
        tx_dw2_d = {payload[15:0], seq_q, status_q};
        state_d  = StSend;
      end

      StSend: begin
        if (tx_ready_in) begin
          seq_d   = seq_q + 8'd1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      op_q        <= '0;
      addr_byte_q <= '0;
      data_q      <= '0;
      status_q    <= StatusOk;
      tx_dw1_q    <= '0;
      tx_dw2_q    <= '0;
      seq_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      op_q        <= op_d;
      addr_byte_q <= addr_byte_d;
      data_q      <= data_d;
      status_q    <= status_d;
      tx_dw1_q    <= tx_dw1_d;
      tx_dw2_q    <= tx_dw2_d;
      seq_q       <= seq_d;
      err_q       <= err_d;
    end
  end

endmodule
